updown_counter: RTL



---
 rtl/updown_counter.sv | 105 ++++++++++
 1 files changed

// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down modulo counter with synchronous load,
// combinational terminal-count flag and a registered wrap/saturation pulse.
//
// Build option:
//   UPDOWN_COUNTER_SAT_EN  - when defined, the counter saturates at 0 / MOD-1
//                            instead of wrapping; wrap then flags a saturation hit.
//
// WIDTH legal range 2..32; MOD legal range 2..2**WIDTH.

module updown_counter #(
    parameter int unsigned      WIDTH = 8,
    parameter longint unsigned  MOD   = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // Largest count value, truncated to the counter width.
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 64'd1);

    // Modulus spans the whole code space: increment/decrement roll over on
    // their own and no load clamp is needed.
    localparam bit FullRange = (MOD == (64'd1 << WIDTH));

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] load_clamped;

    // End-of-range detection, stepped values and clamped load value.
    always_comb begin
        at_max    = (count_q == MaxVal);
        at_zero   = (count_q == '0);
        count_inc = count_q + WIDTH'(1);
        count_dec = count_q - WIDTH'(1);
        if (FullRange) begin
            load_clamped = load_val;
        end else begin
            load_clamped = (load_val > MaxVal) ? MaxVal : load_val;
        end
    end

    // Next-state: rst > load > en > hold; wrap only set by a boundary step.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (rst) begin
            count_d = '0;
            wrap_d  = 1'b0;
        end else if (load) begin
            count_d = load_clamped;
            wrap_d  = 1'b0;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                    count_d = count_q;
`else
                    // Full range rolls over naturally to zero.
                    count_d = FullRange ? count_inc : '0;
`endif
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end else begin
                if (at_zero) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                    count_d = count_q;
`else
                    count_d = FullRange ? count_dec : MaxVal;
`endif
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_dec;
                end
            end
        end
    end

    // State register with synchronous active-high reset folded into next-state.
    always_ff @(posedge clk) begin
        count_q <= count_d;
        wrap_q  <= wrap_d;
    end

    // Outputs: count and wrap registered, tc follows up within the cycle.
    always_comb begin
        count = count_q;
        wrap  = wrap_q;
        tc    = up ? at_max : at_zero;
    end

endmodule
